des_round_ctrl: RTL

//  Sequencer for an iterative (one-round-per-cycle) DES datapath. Accepts a block request with
//  an encrypt/decrypt mode, drives the datapath load/round/finish strobes for 16 rounds, and

---
 rtl/des_pkg.sv | 21 ++
 rtl/des_subkey_mux.sv | 21 ++
 rtl/des_round_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared types, constants and key-order helper for the iterative DES round controller.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int SUBKEY_W   = 48;
    localparam int RIDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Decryption walks the key schedule backwards: K16 first, K1 last.
    function automatic logic [RIDX_W-1:0] subkey_idx(input logic mode,
                                                     input logic [RIDX_W-1:0] ridx);
        return mode ? (RIDX_W'(NUM_ROUNDS - 1) - ridx) : ridx;
    endfunction

endpackage

// File: rtl/des_subkey_mux.sv
// Combinational 16:1 x 48-bit subkey selector; K1 sits in the most significant slice of subkeys.
module des_subkey_mux
    import des_pkg::*;
(
    input  logic [NUM_ROUNDS*SUBKEY_W-1:0] subkeys,
    input  logic [RIDX_W-1:0]              index,
    output logic [SUBKEY_W-1:0]            round_key
);

    logic [SUBKEY_W-1:0] key_arr [NUM_ROUNDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROUNDS; gi++) begin : g_unpack
            assign key_arr[gi] = subkeys[(NUM_ROUNDS-1-gi)*SUBKEY_W +: SUBKEY_W];
        end
    endgenerate

    assign round_key = key_arr[index];

endmodule

// File: rtl/des_round_ctrl.sv
// Round sequencer for a one-round-per-cycle DES datapath: IDLE -> LOAD -> 16 x ROUND -> DONE.
// Optional abort ports are built when DES_ABORT_EN is defined.
module des_round_ctrl
    import des_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_decrypt,
    input  logic [NUM_ROUNDS*SUBKEY_W-1:0] subkeys,
    output logic [SUBKEY_W-1:0]            round_key,
    output logic [RIDX_W-1:0]              round_idx,
    output logic                           dp_load,
    output logic                           dp_round_en,
    output logic                           dp_final,
    output logic                           out_valid,
    input  logic                           out_ready,
`ifdef DES_ABORT_EN
    input  logic                           abort,
    output logic                           abort_ack,
`endif
    output logic                           busy
);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [RIDX_W-1:0] cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              dp_load_q, dp_load_d;
    logic              dp_round_en_q, dp_round_en_d;
    logic              dp_final_q, dp_final_d;
    logic              busy_q, busy_d;
    logic              abort_ack_q, abort_ack_d;
    logic              abort_hit;

`ifdef DES_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
    assign abort_ack = abort_ack_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = LOAD;
                    mode_d  = in_decrypt;
                end
            end
            LOAD:  state_d = ROUND;
            ROUND: begin
                if (cnt_q == RIDX_W'(NUM_ROUNDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = IDLE;
        end

        // Counter is zero entering ROUND and whenever the block is not mid-round.
        cnt_d = (state_q == ROUND && state_d == ROUND) ? cnt_q + RIDX_W'(1) : '0;

        // Strobes are decoded from the next state so they are registered with it.
        in_ready_d    = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        dp_load_d     = (state_d == LOAD);
        dp_round_en_d = (state_d == ROUND);
        dp_final_d    = (state_d == DONE);
        abort_ack_d   = abort_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            dp_load_q     <= 1'b0;
            dp_round_en_q <= 1'b0;
            dp_final_q    <= 1'b0;
            abort_ack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            dp_load_q     <= dp_load_d;
            dp_round_en_q <= dp_round_en_d;
            dp_final_q    <= dp_final_d;
            abort_ack_q   <= abort_ack_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign dp_load     = dp_load_q;
    assign dp_round_en = dp_round_en_q;
    assign dp_final    = dp_final_q;
    assign out_valid   = dp_final_q;
    assign round_idx   = cnt_q;

    des_subkey_mux u_mux (
        .subkeys   (subkeys),
        .index     (subkey_idx(mode_q, cnt_q)),
        .round_key (round_key)
    );

endmodule
